// File: rtl/mul_div_unit.sv
// Iterative unsigned 32x32 multiply / 32-bit restoring divide engine.
// One iteration per clock over a shared 2*DATA_W shift register.
// MUL result is {hi,lo}; DIV result is {remainder, quotient}.
// Optional build macro: MULDIV_ZERO_BYPASS_EN. When it is defined, a zero
// operand (MUL) or zero divisor (DIV) skips the iterations and produces the
// result one cycle after the start.
module mul_div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  mode,
    input  logic [DATA_W-1:0]     in_A,
    input  logic [DATA_W-1:0]     in_B,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   out,
    output logic                  busy
);

    localparam int unsigned RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [RES_W-1:0]  sreg, sreg_nxt;
    logic [RES_W-1:0]  out_nxt;
    logic [DATA_W-1:0] opnd, opnd_nxt;     // multiplicand (MUL) or divisor (DIV)
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_up;
    logic              div_ge;
    logic              last;
    logic              zero_hit;

    // Per-iteration arithmetic: shift-add sum with carry, and restoring trial compare.
    always_comb begin
        mul_sum = {1'b0, sreg[RES_W-1:DATA_W]} + {1'b0, (sreg[0] ? opnd : {DATA_W{1'b0}})};
        div_up  = sreg[RES_W-1:DATA_W-1];
        div_ge  = (div_up >= {1'b0, opnd});
    end

    // Start-time shortcut detection for trivially known results.
    always_comb begin
`ifdef MULDIV_ZERO_BYPASS_EN
        zero_hit = mode ? (in_B == '0) : ((in_A == '0) || (in_B == '0));
`else
        zero_hit = 1'b0;
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        opnd_nxt  = opnd;
        cnt_nxt   = cnt;
        out_nxt   = out;
        last      = (cnt == CNT_W'(DATA_W - 1));
        case (state)
            IDLE: begin
                if (valid) begin
                    opnd_nxt  = mode ? in_B : in_A;
                    sreg_nxt  = mode ? {{DATA_W{1'b0}}, in_A} : {{DATA_W{1'b0}}, in_B};
                    cnt_nxt   = '0;
                    out_nxt   = '0;
                    state_nxt = mode ? DIV : MUL;
                    if (zero_hit) begin
                        out_nxt   = mode ? {in_A, {DATA_W{1'b1}}} : {RES_W{1'b0}};
                        sreg_nxt  = out_nxt;
                        state_nxt = OUT;
                    end
                end
            end
            MUL: begin
                sreg_nxt = {mul_sum, sreg[DATA_W-1:1]};
                cnt_nxt  = cnt + CNT_W'(1);
                if (last) begin
                    out_nxt   = sreg_nxt;
                    state_nxt = OUT;
                end
            end
            DIV: begin
                sreg_nxt = {(div_ge ? DATA_W'(div_up - {1'b0, opnd}) : div_up[DATA_W-1:0]),
                            sreg[DATA_W-2:0], div_ge};
                cnt_nxt  = cnt + CNT_W'(1);
                if (last) begin
                    out_nxt   = sreg_nxt;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            opnd  <= '0;
            cnt   <= '0;
            out   <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            opnd  <= opnd_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
            ready <= (state_nxt == OUT);
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide engine sitting directly downstream of the ALU.
- Consumes the ALU's MUL/DIV request (valid plus mode) and returns the result with a one-cycle ready pulse; the ALU's single-cycle ops never reach this block.
- Unsigned 32x32 shift-add multiplier and 32-bit restoring divider sharing one 64-bit shift register; one iteration per clock.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W wide.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == DATA_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset (sampled on clk rising edge).
- valid  in  1  start request from ALU; sampled only in IDLE.
- mode  in  1  0 = MUL, 1 = DIV; sampled together with valid.
- in_A  in  DATA_W  multiplicand / dividend.
- in_B  in  DATA_W  multiplier / divisor.
- ready  out  1  one-cycle pulse; out is valid while ready is high.
- out  out  2*DATA_W  MUL: full product {hi,lo}; DIV: {remainder, quotient}.
- busy  out  1  high in MUL, DIV and OUT states.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state goes to IDLE; counter=0; shift register=0.
  - out=0, ready=0, busy=0 from the following cycle.
  - Any in-flight operation is discarded with no ready pulse.
- States: IDLE, MUL, DIV, OUT.
- IDLE:
  - At an edge with valid=1, latch in_A, in_B and mode.
  - Clear counter; go to MUL (mode=0) or DIV (mode=1).
  - With valid=0, stay in IDLE.
- MUL, each edge:
  - If the shift register LSB is 1, add the multiplicand to the upper half, with a 33-bit carry.
  - Shift the register right by 1; counter++.
- DIV, each edge (restoring):
  - Shift {rem,quot} left by 1.
  - Trial-subtract the divisor from the upper half.
  - If non-negative, commit the subtraction and set quot LSB=1; else keep the upper half and set quot LSB=0.
  - counter++.
- Leaving MUL/DIV: on the edge where counter==DATA_W-1, the final iteration completes and state goes to OUT.
- OUT:
  - ready=1 and out=result for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: valid sampled at edge T0; iterations at T1..T32; ready high in the cycle after T32 (32 cycles). Back-to-back throughput is one op per 34 cycles.
- out holds the last result after ready falls, until the next accepted start (cleared at T0) or reset.
- valid is ignored while busy=1; no queueing. The ALU must hold off until ready.
- Arithmetic is unsigned throughout. The MUL product is exact across 64 bits.
- DIV by zero: quotient=0xFFFFFFFF, remainder=dividend. This falls out of the restoring algorithm and needs no special casing.
- mode, in_A and in_B changes after T0 have no effect on the running op.
- rst and valid high together: reset wins.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- Defined:
  - At T0, if (MUL and (in_A==0 or in_B==0)) or (DIV and in_B==0), go straight to OUT with the architecturally identical result.
  - MUL result is 0; DIV result is quot=all-ones, rem=in_A.
  - ready is high in the cycle after T0 (latency 1).
- Undefined: every op takes the full 32 iterations; results are identical.

Test Plan:
- MUL: rst, then valid=1, mode=0, A=0x0000_0007, B=0x0000_0006 -> ready pulses exactly 32 cycles later, out=0x0000_0000_0000_002A, busy falls 1 cycle after.
- MUL overflow: A=0xFFFF_FFFF, B=0xFFFF_FFFF -> out=0xFFFF_FFFE_0000_0001.
- DIV: A=100, B=7 -> after 32 cycles out={rem=2, quot=14}; A=0x8000_0000, B=3 -> quot=0x2AAA_AAAA, rem=2.
- DIV by zero: A=0x1234_5678, B=0 -> quot=0xFFFF_FFFF, rem=0x1234_5678. With MULDIV_ZERO_BYPASS_EN, ready comes 1 cycle after T0.
- Busy/ignore: start MUL; at cycle 10 assert valid with mode=1 and new operands -> ignored, original product returned at cycle 32, no second ready.
- Reset mid-op: start DIV; assert rst at cycle 15 -> next cycle busy=0, ready=0, out=0, no ready pulse ever appears; a new op started afterwards completes correctly.
